// File: rtl/mc_pkg.sv
// Cook timer shared types and widths.
// Imported by the interface and every timer block.
package mc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COOK,
    PAUSE,
    DONE
  } mc_state_t;

  localparam int MIN_W       = 4;
  localparam int SEC_W       = 6;
  localparam int PWR_W       = 3;
  localparam int DUTY_PERIOD = 8;
  localparam int DUTY_W      = $clog2(DUTY_PERIOD);

endpackage

// File: rtl/cook_timer_fsm_if.sv
// Keypad-side settings/commands and display/actuator outputs.
// master drives the settings, slave is the timer.
interface cook_timer_fsm_if;
  import mc_pkg::*;

  logic [MIN_W-1:0] time_minutes;
  logic [3:0]       time_seconds;
  logic [PWR_W-1:0] power_level;
  logic             start;
  logic             stop;
  logic             door_open;

  logic             magnetron_on;
  logic             light_on;
  logic             beep;
  logic [MIN_W-1:0] remaining_min;
  logic [SEC_W-1:0] remaining_sec;
  logic             cooking;

  modport master (
    output time_minutes, time_seconds,
    output power_level,
    output start, stop, door_open,
    input  magnetron_on, light_on, beep,
    input  remaining_min, remaining_sec,
    input  cooking
  );

  modport slave (
    input  time_minutes, time_seconds,
    input  power_level,
    input  start, stop, door_open,
    output magnetron_on, light_on, beep,
    output remaining_min, remaining_sec,
    output cooking
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle 1 s tick.
// clr wins over en so a state entry always starts a fresh second.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cook_timer_fsm.sv
// Cooking-cycle controller: countdown, duty-cycled magnetron,
// cavity light and done beeper.
module cook_timer_fsm
  import mc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int BEEP_SECS     = 3
) (
  input logic              clk,
  input logic              rst,
  cook_timer_fsm_if.slave  bus
);

  localparam int BW = $clog2(BEEP_SECS + 1);
  localparam logic [BW-1:0] BEEP_LAST =
    BW'(BEEP_SECS - 1);

  mc_state_t         state_q;
  logic [MIN_W-1:0]  min_q;
  logic [SEC_W-1:0]  sec_q;
  logic [PWR_W-1:0]  power_q;
  logic [DUTY_W-1:0] duty_q;
  logic [BW-1:0]     beep_q;

  logic tick;
  logic pre_en;
  logic start_ok;
  logic has_time;
  logic go_cook;
  logic go_done;

  // stop and door both outrank start
  always_comb begin
    start_ok = bus.start && !bus.stop
               && !bus.door_open;
    has_time = (bus.time_minutes != '0)
               || (bus.time_seconds != '0);
    go_cook  = ((state_q == IDLE) && start_ok && has_time)
               || ((state_q == PAUSE) && start_ok);
    go_done  = (state_q == COOK) && tick
               && !bus.stop && !bus.door_open
               && (min_q == '0) && (sec_q == SEC_W'(1));
    pre_en   = (state_q == COOK) || (state_q == DONE);
  end

  tick_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (go_cook || go_done),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      power_q <= '0;
      duty_q  <= '0;
      beep_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go_cook) begin
            state_q <= COOK;
            min_q   <= bus.time_minutes;
            sec_q   <= SEC_W'(bus.time_seconds);
            power_q <= bus.power_level;
            duty_q  <= '0;
          end
        end
        COOK: begin
          if (bus.stop || bus.door_open) begin
            state_q <= PAUSE;
          end else if (tick) begin
            duty_q <= duty_q + 1'b1;
            if (sec_q == '0) begin
              sec_q <= SEC_W'(59);
              min_q <= min_q - 1'b1;
            end else begin
              sec_q <= sec_q - 1'b1;
            end
            if (go_done) begin
              state_q <= DONE;
              beep_q  <= '0;
            end
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state_q <= IDLE;
            min_q   <= '0;
            sec_q   <= '0;
          end else if (go_cook) begin
            state_q <= COOK;
          end
        end
        DONE: begin
          if (bus.stop || bus.door_open) begin
            state_q <= IDLE;
          end else if (tick) begin
            if (beep_q == BEEP_LAST) begin
              state_q <= IDLE;
            end else begin
              beep_q <= beep_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // door gate stays combinational so the magnetron drops instantly
  assign bus.cooking       = (state_q == COOK);
  assign bus.beep          = (state_q == DONE);
  assign bus.light_on      = bus.cooking || bus.door_open;
  assign bus.magnetron_on  = bus.cooking
                             && (duty_q <= power_q)
                             && !bus.door_open;
  assign bus.remaining_min = min_q;
  assign bus.remaining_sec = sec_q;

endmodule

// File: doc/cook_timer_fsm.md
Name: cook_timer_fsm

Overview:
- Cooking-cycle controller directly downstream of the keypad interface.
- Consumes the keypad's minutes, seconds and power-level settings plus start, stop and door inputs.
- Runs a 1 s countdown and drives the magnetron with a power-level duty cycle, the cavity light and the done beeper.
- Provides the remaining time to the display stage.

Parameters:
- TICKS_PER_SEC, 50_000_000, clk cycles per 1 s tick; the bench uses 4.
- BEEP_SECS, 3, seconds the beeper sounds in DONE.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- time_minutes  in  4  keypad minutes setting, 0..15
- time_seconds  in  4  keypad seconds setting, 0..15
- power_level  in  3  keypad power level, 0..7
- start  in  1  single-cycle start/resume pulse
- stop  in  1  single-cycle stop/clear pulse
- door_open  in  1  door switch level, 1 = open
- magnetron_on  out  1  magnetron enable
- light_on  out  1  cavity light
- beep  out  1  beeper enable
- remaining_min  out  4  remaining minutes
- remaining_sec  out  6  remaining seconds, 0..59
- cooking  out  1  high when state is COOK

Behaviour:
- States: IDLE, COOK, PAUSE, DONE.
- Reset (async, any state) produces:
  - state IDLE, remaining_min = 0, remaining_sec = 0;
  - prescaler = 0, duty_phase = 0, power_q = 0, beep_cnt = 0;
  - all outputs 0, except light_on, which follows door_open.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only while in COOK or DONE.
  - tick is asserted for one cycle at the wrap.
  - The prescaler clears on every entry to COOK and to DONE.
- Priority each cycle: stop > door_open > start > tick.
- IDLE:
  - On start && !door_open && (time_minutes != 0 || time_seconds != 0): go to COOK.
  - On that entry, load remaining_min = time_minutes and remaining_sec = time_seconds, latch power_q = power_level, and set duty_phase = 0.
  - start with a zero time, or with the door open, is ignored.
  - Setting changes while not in IDLE are ignored.
- COOK:
  - stop goes to PAUSE.
  - door_open goes to PAUSE, and a tick in the same cycle is discarded.
  - On tick: if remaining_sec == 0, set remaining_sec = 59 and decrement remaining_min; otherwise decrement remaining_sec.
  - Also on tick, duty_phase increments and wraps 7 to 0.
  - When the decrement makes the value 0:00, go to DONE the cycle after that tick.
  - The count never underflows.
- PAUSE:
  - Counter and duty_phase are held.
  - start && !door_open resumes COOK, with the prescaler cleared.
  - stop clears remaining time to 0:00 and goes to IDLE.
- DONE:
  - beep = 1.
  - beep_cnt counts ticks; after BEEP_SECS ticks, go to IDLE with beep = 0.
  - stop or door_open goes to IDLE immediately.
- magnetron_on = (state == COOK) && (duty_phase <= power_q) && !door_open.
  - The door gate is combinational with zero latency; this is a safety requirement.
  - Result: on for power_q+1 of every 8 seconds, so level 7 gives continuous operation.
- light_on = (state == COOK) || door_open.
- cooking = (state == COOK).
- remaining_min and remaining_sec are registered and update on the clk edge that consumes the tick.
- Width rule: a loaded seconds value of 0..15 is never normalised. For example, 1:15 counts down to 1:00, then 0:59.

Decomposition:
- Package mc_pkg contains:
  - enum mc_state_t {IDLE, COOK, PAUSE, DONE};
  - localparams MIN_W = 4, SEC_W = 6, PWR_W = 3, DUTY_PERIOD = 8.
- One sub-module, tick_prescaler:
  - parameter TICKS_PER_SEC;
  - inputs clk, rst, en, clr; output tick.
- The FSM, the counters and the duty logic live in cook_timer_fsm.

Test Plan (TICKS_PER_SEC = 4, BEEP_SECS = 3):
- Set 0:03, power 7, pulse start:
  - cooking rises the next cycle;
  - remaining time steps 0:02, 0:01, 0:00 at 4-cycle intervals;
  - magnetron_on stays continuously 1;
  - the FSM enters DONE, beep is high for 12 cycles, then the FSM returns to IDLE.
- Set 1:00, power 1, start:
  - remaining time shows 0:59 after the first tick;
  - magnetron_on is 1 for 2 s, 0 for 6 s, repeating.
- Open the door mid-COOK at 0:10:
  - magnetron_on falls in the same cycle and light_on = 1;
  - state is PAUSE and the count holds at 0:10.
  - Close the door and pulse start: counting resumes from 0:10.
- Stop in COOK gives PAUSE with the time held; a second stop gives IDLE and 0:00.
- Pulse start and stop in the same cycle while in COOK: the FSM goes to PAUSE, since stop wins.
- Start with 0:00, or with the door open: no state change and magnetron_on stays 0.
- Assert rst mid-COOK at 0:05:
  - all outputs 0 asynchronously and the FSM is in IDLE;
  - after release, start with 0:02 runs normally.
